// File: rtl/arp_sample_gen.sv
// Arpeggiated tone sample generator.
// A phase accumulator is stepped once per sample period by the increment of
// the current arpeggio note (root, major third, fifth, octave). The new phase
// is shaped arithmetically into a saw, square, triangle or silent sample.
// A note sequencer advances the arpeggio every NOTE_SAMPLES samples.
module arp_sample_gen #(
    parameter int SAMPLE_DIV   = 2048,  // clk cycles per sample period, >= 2
    parameter int NOTE_SAMPLES = 12207, // samples per arpeggio note, >= 1
    parameter int PHASE_BITS   = 24,    // phase accumulator / increment width
    parameter int OUT_BITS     = 8      // sample width, <= PHASE_BITS - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PHASE_BITS-1:0] base_inc,
    input  logic [1:0]            mode,
    input  logic [1:0]            wave_sel,
    output logic [OUT_BITS-1:0]   sample_out,
    output logic                  sample_strobe,
    output logic [1:0]            note_idx,
    output logic                  note_strobe
);

    // ------------------------------------------------------------------
    // Local types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ARP_UP     = 2'b00,
        ARP_DOWN   = 2'b01,
        ARP_UPDOWN = 2'b10,
        ARP_HOLD   = 2'b11
    } arp_mode_e;

    typedef enum logic [1:0] {
        WAVE_SAW     = 2'b00,
        WAVE_SQUARE  = 2'b01,
        WAVE_TRI     = 2'b10,
        WAVE_SILENCE = 2'b11
    } wave_e;

    // Counter widths never collapse to zero, even for degenerate parameters.
    localparam int DIV_W  = (SAMPLE_DIV   > 1) ? $clog2(SAMPLE_DIV)   : 1;
    localparam int NOTE_W = (NOTE_SAMPLES > 1) ? $clog2(NOTE_SAMPLES) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [NOTE_W-1:0]   NOTE_LAST = NOTE_W'(NOTE_SAMPLES - 1);
    localparam logic [OUT_BITS-1:0] MIDSCALE  = {1'b1, {(OUT_BITS-1){1'b0}}};
    localparam logic [OUT_BITS-1:0] ALL_ONES  = {OUT_BITS{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]      div_cnt_q;
    logic [NOTE_W-1:0]     note_cnt_q;
    logic [PHASE_BITS-1:0] phase_q;
    logic [1:0]            note_idx_q;
    logic                  dir_q;        // up-down direction: 0 up, 1 down
    logic                  ud_active_q;  // last advance was made in up-down mode
    logic [OUT_BITS-1:0]   sample_q;
    logic                  sample_strobe_q;
    logic                  note_strobe_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  sample_edge;
    logic                  note_last;
    logic                  note_advance;

    assign sample_edge  = enable && (div_cnt_q == DIV_LAST);
    assign note_last    = (note_cnt_q == NOTE_LAST);
    assign note_advance = sample_edge && note_last;

    // Note increments are formed one bit wider, then wrapped back to the
    // accumulator width; the octave aliases for large root increments.
    logic [PHASE_BITS:0]   base_ext;
    logic [PHASE_BITS:0]   inc_third_w;
    logic [PHASE_BITS:0]   inc_fifth_w;
    logic [PHASE_BITS:0]   inc_oct_w;
    logic [PHASE_BITS-1:0] inc_sel;
    logic [PHASE_BITS-1:0] phase_n;

    assign base_ext    = {1'b0, base_inc};
    assign inc_third_w = base_ext + (base_ext >> 2);
    assign inc_fifth_w = base_ext + (base_ext >> 1);
    assign inc_oct_w   = base_ext << 1;

    // Select the increment of the note currently sounding.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        inc_sel = base_inc;
        case (note_idx_q)
            2'd0:    inc_sel = base_inc;
            2'd1:    inc_sel = inc_third_w[PHASE_BITS-1:0];
            2'd2:    inc_sel = inc_fifth_w[PHASE_BITS-1:0];
            2'd3:    inc_sel = inc_oct_w[PHASE_BITS-1:0];
            default: inc_sel = base_inc;
        endcase
    end

    assign phase_n = phase_q + inc_sel;

    // Waveform shaping from the upper phase bits of the next phase.
    logic [OUT_BITS-1:0] top;
    logic [OUT_BITS-1:0] top_dbl;
    logic                msb;
    logic [OUT_BITS-1:0] wave_n;

    assign top     = phase_n[PHASE_BITS-1 -: OUT_BITS];
    assign top_dbl = top << 1;
    assign msb     = phase_n[PHASE_BITS-1];

    // Map the next phase to a sample according to the selected waveform.
    always_comb begin
        wave_n = MIDSCALE;
        case (wave_e'(wave_sel))
            WAVE_SAW:     wave_n = top;
            WAVE_SQUARE:  wave_n = msb ? ALL_ONES : '0;
            WAVE_TRI:     wave_n = msb ? ~top_dbl : top_dbl;
            WAVE_SILENCE: wave_n = MIDSCALE;
            default:      wave_n = MIDSCALE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arpeggio advance candidate (applied only on a note advance)
    // ------------------------------------------------------------------
    logic [1:0] note_idx_d;
    logic       dir_d;
    logic       ud_active_d;
    logic       eff_down;

    // Work out the next note index and up-down direction for the current mode.
    always_comb begin
        note_idx_d  = note_idx_q;
        dir_d       = dir_q;
        eff_down    = 1'b0;
        ud_active_d = (arp_mode_e'(mode) == ARP_UPDOWN);
        case (arp_mode_e'(mode))
            ARP_UP:   note_idx_d = note_idx_q + 2'd1;
            ARP_DOWN: note_idx_d = note_idx_q - 2'd1;
            ARP_HOLD: note_idx_d = 2'd0;
            ARP_UPDOWN: begin
                // Entering up-down from another mode restarts upward; the
                // endpoints always turn around so no end note repeats.
                eff_down = ud_active_q ? dir_q : 1'b0;
                if (note_idx_q == 2'd3) begin
                    eff_down = 1'b1;
                end else if (note_idx_q == 2'd0) begin
                    eff_down = 1'b0;
                end
                note_idx_d = eff_down ? (note_idx_q - 2'd1) : (note_idx_q + 2'd1);
                if (note_idx_d == 2'd3) begin
                    dir_d = 1'b1;
                end else if (note_idx_d == 2'd0) begin
                    dir_d = 1'b0;
                end else begin
                    dir_d = eff_down;
                end
            end
            default: note_idx_d = note_idx_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Sample-period divider: counts while enabled, parked at zero when paused.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values of the others, independent of block order.
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else if (!enable) begin
            div_cnt_q <= '0;
        end else if (sample_edge) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Phase accumulator, output sample and sample strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q         <= '0;
            sample_q        <= MIDSCALE;
            sample_strobe_q <= 1'b0;
        end else if (!enable) begin
            sample_q        <= MIDSCALE;
            sample_strobe_q <= 1'b0;
        end else begin
            sample_strobe_q <= sample_edge;
            if (sample_edge) begin
                phase_q  <= phase_n;
                sample_q <= wave_n;
            end
        end
    end

    // Note sequencer: counts samples per note and advances the arpeggio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_cnt_q    <= '0;
            note_idx_q    <= 2'd0;
            dir_q         <= 1'b0;
            ud_active_q   <= 1'b0;
            note_strobe_q <= 1'b0;
        end else if (!enable) begin
            note_strobe_q <= 1'b0;
        end else begin
            note_strobe_q <= note_advance;
            if (sample_edge) begin
                if (note_last) begin
                    note_cnt_q  <= '0;
                    note_idx_q  <= note_idx_d;
                    dir_q       <= dir_d;
                    ud_active_q <= ud_active_d;
                end else begin
                    note_cnt_q <= note_cnt_q + NOTE_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sample_out    = sample_q;
    assign sample_strobe = sample_strobe_q;
    assign note_idx      = note_idx_q;
    assign note_strobe   = note_strobe_q;

endmodule
